// File: rtl/alu_shuffle_iter_pkg.sv
// Shared encodings for the iterative perfect-shuffle / unshuffle unit.
// Mode and FSM state types are used by both the top and the step datapath.
package alu_shuffle_iter_pkg;

  typedef enum logic {
    SHUF_MODE_SHUFFLE   = 1'b0,
    SHUF_MODE_UNSHUFFLE = 1'b1
  } shuf_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } shuf_state_e;

endpackage

// File: rtl/alu_shuffle_iter_step.sv
// One combinational shuffle (interleave halves) or unshuffle (de-interleave) step.
// Shuffle sends bit i to index rotl(i); unshuffle is its exact inverse.
module alu_shuffle_step
  import alu_shuffle_iter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] d,
  input  logic              mode,
  output logic [DATA_W-1:0] r
);

  localparam int HALF = DATA_W / 2;

  always_comb begin
    r = '0;
    for (int i = 0; i < HALF; i++) begin
      if (mode == SHUF_MODE_UNSHUFFLE) begin
        r[i]        = d[2*i];
        r[i + HALF] = d[2*i + 1];
      end else begin
        r[2*i]      = d[i];
        r[2*i + 1]  = d[i + HALF];
      end
    end
  end

endmodule

// File: rtl/alu_shuffle_iter.sv
// Iterative shuffle/unshuffle unit: accepts an operand, applies in_count steps
// one per cycle, then holds the result until the consumer takes it.
//
// state   | meaning
// IDLE    | ready for a request, outputs zero
// RUN     | applying one step per cycle, counter counting down
// DONE    | result held on out_data until out_ready
module alu_shuffle_iter
  import alu_shuffle_iter_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int CNT_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_mode,
  input  logic [CNT_W-1:0]  in_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  shuf_state_e       state_q;
  shuf_mode_e        mode_q;
  logic [DATA_W-1:0] work_q;
  logic [DATA_W-1:0] work_d;
  logic [CNT_W-1:0]  cnt_q;

  alu_shuffle_step #(.DATA_W(DATA_W)) u_step (
    .d    (work_q),
    .mode (mode_q),
    .r    (work_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= SHUF_MODE_SHUFFLE;
      work_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            work_q  <= in_data;
            mode_q  <= shuf_mode_e'(in_mode);
            cnt_q   <= in_count;
            state_q <= (in_count != '0) ? ST_RUN : ST_DONE;
          end
        end
        ST_RUN: begin
          work_q <= work_d;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          // No re-accept on the handshake edge; IDLE offers in_ready next cycle.
          if (out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = out_valid ? work_q : '0;

endmodule

// File: doc/alu_shuffle_iter.md
ALU_SHUFFLE_ITER -- requirements
Module: alu_shuffle_iter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width in bits; legal values are powers of two, 4 to 256.
REQ-002 SHALL have derived localparam CNT_W = clog2(DATA_W), the width of the step-count field.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; reset is synchronous and active-high.
REQ-004 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit, meaning a request is offered.
REQ-006 SHALL have port in_ready, output, 1 bit, meaning the block can accept a request.
REQ-007 SHALL have port in_data, input, DATA_W bits, the operand.
REQ-008 SHALL have port in_mode, input, 1 bit: 0 = perfect shuffle (interleave halves), 1 = unshuffle (de-interleave).
REQ-009 SHALL have port in_count, input, CNT_W bits, the number of shuffle/unshuffle steps to apply.
REQ-010 SHALL have port out_valid, output, 1 bit, meaning a result is held.
REQ-011 SHALL have port out_ready, input, 1 bit, meaning the consumer accepts the result.
REQ-012 SHALL have port out_data, output, DATA_W bits, the result.
REQ-013 SHALL have port busy, output, 1 bit, high whenever the FSM is not in IDLE.

Function
REQ-014 Shuffle step SHALL map r[2i]=d[i] and r[2i+1]=d[i+DATA_W/2], for i in 0..DATA_W/2-1.
REQ-015 Unshuffle step SHALL map r[i]=d[2i] and r[i+DATA_W/2]=d[2i+1]; unshuffle is the exact inverse of shuffle.
REQ-016 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; an accept occurs on the edge where in_valid and in_ready are both 1.
REQ-018 On accept, the block SHALL latch in_data into the working register, latch in_mode, and latch in_count into the remaining-steps counter.
REQ-019 On accept, the next state SHALL be RUN if in_count != 0, else DONE.
REQ-020 In RUN, each cycle SHALL apply one step to the working register and decrement the counter; when the counter equals 1, the next state SHALL be DONE.
REQ-021 Latency SHALL be in_count+1 cycles from the accept edge to out_valid high; count 0 gives 1 cycle with data unchanged.
REQ-022 In DONE, out_valid SHALL be 1 and out_data SHALL equal the working register; it SHALL stay stable while out_ready is 0.
REQ-023 When out_valid and out_ready are both 1, the FSM SHALL return to IDLE on that edge; in_ready rises the next cycle (no same-cycle re-accept; throughput is one request per count+2 cycles).
REQ-024 Inputs changing after accept SHALL have no effect on the transaction in flight.
REQ-025 in_count values >= CNT_W SHALL be legal and executed literally; because CNT_W steps give the identity, the result equals count mod CNT_W steps.
REQ-026 out_data SHALL be 0 whenever out_valid is 0.

Reset
REQ-027 rst SHALL be sampled on the rising clk edge and take priority over every other event, including an accept or handshake in the same cycle.
REQ-028 Reset SHALL force: state IDLE, working register 0, counter 0, latched mode 0.
REQ-029 The resulting outputs SHALL be in_ready=1, out_valid=0, out_data=0 and busy=0 from the first cycle after reset.
REQ-030 Reset in RUN or DONE SHALL abandon the transaction with no output produced.

Structure
REQ-031 A shared package or include SHALL hold the mode encodings (SHUF_MODE_SHUFFLE=0, SHUF_MODE_UNSHUFFLE=1) and the state encodings.
REQ-032 A combinational sub-module alu_shuffle_step (parameter DATA_W; ports d, mode, r) SHALL implement one step.
REQ-033 alu_shuffle_step SHALL be instantiated once, feeding the working register.

Verification (DATA_W=32)
REQ-034 Shuffle, count 1, data 0x0000FFFF -> 0x55555555 with out_valid 2 cycles after accept.
REQ-035 Unshuffle, count 1, data 0x55555555 -> 0x0000FFFF.
REQ-036 Shuffle, count 2, data 0x0000FFFF -> 0x33333333 at latency 3; shuffle, count 5, data 0x12345678 -> 0x12345678 (identity).
REQ-037 Count 0, data 0xDEADBEEF -> 0xDEADBEEF at latency 1; out_ready held 0 for 4 cycles -> out_data stable, in_ready 0 throughout.
REQ-038 Accept, count 7, assert rst in cycle 3 -> next cycle in_ready=1, out_valid=0, out_data=0, and no result is emitted.
REQ-039 Random back-to-back traffic with random out_ready stalls -> each result matches the reference model, with in-order, lossless delivery.
